// File: rtl/fifo_rd_packer.sv
// Read-side packer: pops FIFO words and packs PACK_RATIO of them, little-endian,
// into one wide beat on a valid/ready output; FLUSH closes a partial beat.
//
// state  | meaning
// S_FILL | collecting words into the lane buffer, o_out_valid=0
// S_HOLD | beat presented on the output, waiting for o_out_valid & i_out_ready
module fifo_rd_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK_RATIO = 4,
  parameter int CNT_W      = $clog2(PACK_RATIO + 1)
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_empty,
  input  logic [DATA_WIDTH-1:0]            i_rd_data,
  output logic                             o_r_inc,
  input  logic                             i_flush,
  output logic [DATA_WIDTH*PACK_RATIO-1:0] o_out_data,
  output logic [CNT_W-1:0]                 o_out_cnt,
  output logic                             o_out_last,
  output logic                             o_out_valid,
  input  logic                             i_out_ready
);

  typedef enum logic {S_FILL, S_HOLD} state_t;

  localparam int OUT_W = DATA_WIDTH * PACK_RATIO;

  state_t                  r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [OUT_W-1:0]        r_data;
  logic [CNT_W-1:0]        r_out_cnt;
  logic                    r_out_last;
  logic                    r_valid;

  logic                    w_pop;
  logic [CNT_W-1:0]        w_cnt_next;
  logic                    w_full;

  // Popping during HOLD only when the beat leaves this cycle keeps the FIFO side bubble-free.
  assign w_pop = !i_rst && !i_empty &&
                 ((r_state == S_FILL) || ((r_state == S_HOLD) && i_out_ready));

  assign w_cnt_next = r_cnt + CNT_W'(1);
  assign w_full     = (w_cnt_next == CNT_W'(PACK_RATIO));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_FILL;
      r_cnt      <= '0;
      r_data     <= '0;
      r_out_cnt  <= '0;
      r_out_last <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      case (r_state)
        S_FILL: begin
          if (w_pop) begin
            for (int l = 0; l < PACK_RATIO; l++) begin
              if (r_cnt == CNT_W'(l)) begin
                r_data[l*DATA_WIDTH +: DATA_WIDTH] <= i_rd_data;
              end
            end
            if (w_full) begin
              // A flush coinciding with the final pop only marks the full beat as last.
              r_state    <= S_HOLD;
              r_valid    <= 1'b1;
              r_out_cnt  <= CNT_W'(PACK_RATIO);
              r_out_last <= i_flush;
              r_cnt      <= '0;
            end else if (i_flush) begin
              r_state    <= S_HOLD;
              r_valid    <= 1'b1;
              r_out_cnt  <= w_cnt_next;
              r_out_last <= 1'b1;
              r_cnt      <= '0;
            end else begin
              r_cnt <= w_cnt_next;
            end
          end else if (i_flush && (r_cnt != '0)) begin
            r_state    <= S_HOLD;
            r_valid    <= 1'b1;
            r_out_cnt  <= r_cnt;
            r_out_last <= 1'b1;
            r_cnt      <= '0;
          end
        end
        S_HOLD: begin
          if (i_out_ready) begin
            r_state    <= S_FILL;
            r_valid    <= 1'b0;
            r_out_cnt  <= '0;
            r_out_last <= 1'b0;
            if (w_pop) begin
              r_data <= {{(OUT_W-DATA_WIDTH){1'b0}}, i_rd_data};
              r_cnt  <= CNT_W'(1);
            end else begin
              r_data <= '0;
              r_cnt  <= '0;
            end
          end
        end
        default: begin
          r_state <= S_FILL;
        end
      endcase
    end
  end

  assign o_r_inc     = w_pop;
  assign o_out_data  = r_data;
  assign o_out_cnt   = r_out_cnt;
  assign o_out_last  = r_out_last;
  assign o_out_valid = r_valid;

endmodule
